// File: rtl/genram_master.sv
// ============================================================================
// Module   : genram_master
// Brief    : Burst read/write initiator that is the sole driver of a genram
//            single-port RAM, with valid/ready request, write and read channels.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module genram_master #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rw,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_RD_HOLD  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] remain_q, remain_d;
  logic          done_q, done_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_last_q, rd_last_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    done_d     = 1'b0;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_data_d  = rd_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          remain_d = req_len;
          state_d  = req_write ? S_WR : S_RD_ISSUE;
        end
      end
      S_WR: begin
        if (wr_valid) begin
          addr_d = addr_q + 1'b1;
          if (remain_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            remain_d = remain_q - 1'b1;
          end
        end
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        rd_data_d  = ram_rdata;
        rd_valid_d = 1'b1;
        rd_last_d  = (remain_q == '0);
        state_d    = S_RD_HOLD;
      end
      S_RD_HOLD: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          if (remain_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d   = addr_q + 1'b1;
            remain_d = remain_q - 1'b1;
            state_d  = S_RD_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write strobes are gated by rst_n so an edge that resets never writes the RAM.
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign wr_ready  = (state_q == S_WR) && rst_n;
  assign ram_rw    = !((state_q == S_WR) && wr_valid && rst_n);
  assign ram_addr  = addr_q;
  assign ram_wdata = (state_q == S_WR) ? wr_data : '0;
  assign done      = done_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign rd_data   = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_genram_master.sv
// ============================================================================
// Module   : tb_genram_master
// Brief    : Randomized self-checking bench for genram_master with a genram
//            model and a word-array reference of the RAM contents.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_genram_master;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n, req_valid, req_write, wr_valid, rd_ready;
  logic [AW-1:0] req_addr, req_len;
  logic [DW-1:0] wr_data;
  logic          req_ready, wr_ready, rd_valid, rd_last, busy, done, ram_rw;
  logic [DW-1:0] rd_data, ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  genram_master #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_rw(ram_rw), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // genram model: synchronous write when rw=0, registered read data
  logic [DW-1:0] mem [N];
  int n_wr = 0;
  int cyc  = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!ram_rw) begin
      mem[ram_addr] <= ram_wdata;
      n_wr <= n_wr + 1;
    end
    ram_rdata <= mem[ram_addr];
  end

  logic [DW-1:0] ref_mem [N];
  logic [DW-1:0] wq[$];
  int            stall_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_vec++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int next_stall(input int maxs);
    if (stall_q.size() > 0) return stall_q.pop_front();
    return $urandom_range(0, maxs);
  endfunction

  task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] len, input int maxs);
    int            wr0, s;
    logic [AW-1:0] ea;
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = len;
    #1;
    check("wr_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    wr0 = n_wr;
    check("wr_busy", busy, 1);
    for (int i = 0; i <= int'(len); i++) begin
      ea = a + AW'(i);
      s  = next_stall(maxs);
      repeat (s) begin
        wr_valid = 1'b0;
        #1;
        check("stall_rw", ram_rw, 1);
        check("stall_addr", ram_addr, ea);
        tick();
      end
      wr_valid = 1'b1;
      wr_data  = wq[i];
      #1;
      check("wr_ready", wr_ready, 1);
      check("wr_rw", ram_rw, 0);
      check("wr_addr", ram_addr, ea);
      check("wr_wdata", ram_wdata, wq[i]);
      ref_mem[ea] = wq[i];
      tick();
    end
    wr_valid = 1'b0;
    #1;
    check("wr_done", done, 1);
    check("wr_end_busy", busy, 0);
    check("wr_count", n_wr - wr0, int'(len) + 1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] len, input int maxs,
                         input bit hold);
    int            c0, s, tot;
    logic [AW-1:0] ea;
    logic [DW-1:0] ev;
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = len;
    #1;
    check("rd_req_ready", req_ready, 1);
    tick();
    c0  = cyc;
    tot = 0;
    if (!hold) req_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      ea = a + AW'(i);
      ev = ref_mem[ea];
      #1;
      check("iss_addr", ram_addr, ea);
      check("iss_rw", ram_rw, 1);
      check("iss_rvalid", rd_valid, 0);
      if (hold) check("hold_req_ready", req_ready, 0);
      tick();
      check("wait_rvalid", rd_valid, 0);
      tick();
      s   = next_stall(maxs);
      tot = tot + 3 + s;
      for (int k = 0; k <= s; k++) begin
        check("hold_rvalid", rd_valid, 1);
        check("hold_rdata", rd_data, ev);
        check("hold_rlast", rd_last, (i == int'(len)));
        check("hold_addr", ram_addr, ea);
        if (hold) check("hold_req_ready", req_ready, 0);
        if (k < s) tick();
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    #1;
    check("rd_done", done, 1);
    check("rd_end_rvalid", rd_valid, 0);
    check("rd_end_rlast", rd_last, 0);
    check("rd_end_busy", busy, 0);
    check("rd_cycles", cyc - c0, tot);
    if (hold) check("done_req_ready", req_ready, 1);
  endtask

  task automatic idle_gap();
    int g;
    g = $urandom_range(0, 2);
    req_valid = 1'b0;
    repeat (g) begin
      tick();
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_wr_ready"}, wr_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ram_rw"}, ram_rw, 1);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_ram_wdata"}, ram_wdata, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_last"}, rd_last, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    int w0;
    logic [AW-1:0] ra, rl;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // fill every word with a full-length wrapping burst, then read it all back
    wq.delete();
    repeat (N) wq.push_back($urandom);
    ra = AW'($urandom);
    do_write(ra, AW'(N - 1), 1);
    do_read(AW'($urandom), AW'(N - 1), 1, 1'b0);

    wq = '{32'hFFFF_FFFF};
    do_write(4'd1, 4'd0, 0);
    do_read(4'd1, 4'd0, 0, 1'b0);

    wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_write(4'd14, 4'd3, 0);
    do_read(4'd14, 4'd3, 0, 1'b0);

    wq = '{$urandom, $urandom};
    stall_q = '{0, 2};
    do_write(4'd9, 4'd1, 0);

    stall_q = '{5, 0};
    do_read(4'd3, 4'd1, 0, 1'b0);

    // reset on beat 2 of a 4-beat write: words 6 and 7 must keep old data
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd4; req_len = 4'd3;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_data = 32'h55;
      ref_mem[4 + i] = 32'h55;
      tick();
    end
    wr_valid = 1'b1;
    rst_n = 1'b0;
    w0 = n_wr;
    #1;
    check("rst_mid_rw", ram_rw, 1);
    tick();
    check("rst_mid_nowrite", n_wr - w0, 0);
    check_reset_outputs("rst_mid");
    rst_n = 1'b1;
    wr_valid = 1'b0;
    tick();
    check("rst_mid_no_done", done, 0);
    check("rst_mid_idle", busy, 0);
    do_read(4'd4, 4'd3, 0, 1'b0);

    do_read(4'd8, 4'd3, 1, 1'b1);
    do_read(4'd2, 4'd0, 0, 1'b0);
    idle_gap();

    for (int k = 0; k < 30; k++) begin
      ra = AW'($urandom);
      rl = ($urandom_range(0, 7) == 0) ? AW'(N - 1) : AW'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        for (int i = 0; i <= int'(rl); i++) wq.push_back($urandom);
        do_write(ra, rl, 2);
      end else begin
        do_read(ra, rl, 2, 1'b0);
      end
      idle_gap();
    end

    do_read(4'd0, AW'(N - 1), 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/genram_master.md
# genram_master

Initiator-side controller for the `genram` single-port RAM. It accepts burst read/write requests from a client (pipeline stage or DMA-style sequencer) over a valid/ready handshake and drives the RAM's `addr`/`rw`/`data_in` pins. It streams write beats in and read beats out with per-beat handshakes. It sits between the MIPS datapath/test sequencers and any `genram` instance, and it is the only agent that drives that RAM's port.

## Interface
Parameters:
- `AW`, 4: RAM address width; the address space is 2^AW words.
- `DW`, 32: data word width.

Ports:
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_write`  in  1  1 = write burst, 0 = read burst.
- `req_addr`  in  AW  start address.
- `req_len`  in  AW  burst length minus 1 (0 means 1 beat, max 2^AW beats).
- `wr_valid`  in  1  write beat data present.
- `wr_ready`  out  1  write beat accepted this cycle if `wr_valid` is high.
- `wr_data`  in  DW  write beat data.
- `rd_valid`  out  1  read beat present.
- `rd_ready`  in  1  client accepts the read beat.
- `rd_data`  out  DW  read beat data.
- `rd_last`  out  1  qualifies the final beat of a read burst.
- `busy`  out  1  a burst is in progress (state is not IDLE).
- `done`  out  1  one-cycle pulse after the last beat of any burst completes.
- `ram_addr`  out  AW  to genram `addr`.
- `ram_rw`  out  1  to genram `rw`: 0 = write, 1 = read.
- `ram_wdata`  out  DW  to genram `data_in`.
- `ram_rdata`  in  DW  from genram `data_out`; registered, valid 1 cycle after the read address is presented with `ram_rw`=1.

## Operation
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, RD_HOLD.
- Internal registers: `addr` (AW bits), `remain` (AW bits, beats left minus 1), `done`, and the read output registers.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: load `addr`←`req_addr` and `remain`←`req_len`.
  - Go to WR if `req_write`=1, else go to RD_ISSUE.
- WR:
  - `wr_ready`=1, `ram_wdata`=`wr_data`, `ram_rw`=~`wr_valid`. These are combinational, so the RAM write happens on the same edge as the handshake.
  - Each accepted beat: `addr`←`addr`+1.
  - If `remain`==0, go to IDLE and pulse `done`; else `remain`←`remain`-1.
  - A cycle with `wr_valid`=0 stalls: no write occurs and nothing advances.
- RD_ISSUE:
  - `ram_addr`=`addr`, `ram_rw`=1. Go to RD_WAIT.
- RD_WAIT:
  - Capture `rd_data`←`ram_rdata`.
  - Set `rd_valid`←1 and `rd_last`←(`remain`==0). Go to RD_HOLD.
- RD_HOLD:
  - Hold `rd_data`, `rd_valid` and `rd_last` stable until `rd_ready`.
  - On the handshake, clear `rd_valid`/`rd_last`.
  - If this was the last beat, go to IDLE and pulse `done`.
  - Otherwise `addr`←`addr`+1, `remain`←`remain`-1, go to RD_ISSUE.
- `ram_rw`=1 in every state except WR with `wr_valid`=1. The RAM is never written outside an accepted write beat.
- `ram_addr`=`addr` in all states. `ram_wdata`=`wr_data` in WR and 0 elsewhere.
- Address arithmetic is modulo 2^AW: a burst crossing address 2^AW-1 wraps to 0. A full-length burst (`req_len`=2^AW-1) touches every word exactly once.
- `req_ready`=0 outside IDLE; requests presented while busy are not consumed.
- Reset (`rst_n`=0 at a rising edge), whether idle or mid-burst:
  - State returns to IDLE and the burst is abandoned with no `done`.
  - `addr`=0, `remain`=0, `rd_valid`=0, `rd_last`=0, `rd_data`=0, `done`=0.
  - Combinational outputs take their IDLE values: `req_ready`=1, `wr_ready`=0, `busy`=0, `ram_rw`=1, `ram_addr`=0, `ram_wdata`=0.
  - No RAM write occurs on any edge at which `rst_n`=0.

## Timing
- Request acceptance: same edge as `req_valid`&&`req_ready`; `busy`=1 from the next cycle.
- Write: 1 cycle per beat at full rate. An N-beat write takes N cycles in WR. `done` is high the cycle after the last beat.
- Read: 3 cycles per beat minimum (RD_ISSUE, RD_WAIT, RD_HOLD with `rd_ready`=1). `rd_valid` rises 2 cycles after entering RD_ISSUE. Each `rd_ready` stall cycle adds 1 cycle.
- `done` is high for exactly 1 cycle, concurrent with the return to IDLE. A new request is acceptable in that same cycle.
- `rd_data` and `rd_last` change only on entry to RD_HOLD or on reset.

## Test plan
- Single write then read:
  - Stimulus: write `req_addr`=1, `req_len`=0, `wr_data`=32'hFFFFFFFF; then read `req_addr`=1, `req_len`=0.
  - Required: 1 write cycle with `ram_rw`=0, `ram_addr`=1. Then `rd_data`=32'hFFFFFFFF, `rd_last`=1, and `done` pulses once per burst.
- Wrapping burst:
  - Stimulus: write `req_addr`=14, `req_len`=3, data 32'hA0..32'hA3; then read back from 14 with `req_len`=3.
  - Required: writes go to addresses 14, 15, 0, 1. The read returns A0, A1, A2, A3, with `rd_last` only on A3.
- Write stalls:
  - Stimulus: `wr_valid` toggled 1,0,0,1 during a 2-beat write.
  - Required: `ram_rw`=1 during the stall cycles, `addr` unchanged across the stall, exactly 2 RAM writes.
- Read backpressure:
  - Stimulus: `rd_ready`=0 for 5 cycles on beat 0 of a 2-beat read.
  - Required: `rd_valid`/`rd_data` held stable and no new RAM read issued until the handshake. Total read time is 11 cycles.
- Reset mid-burst:
  - Stimulus: assert `rst_n`=0 during beat 2 of a 4-beat write of 32'h55.
  - Required: no further writes, no `done`, all outputs at reset values. Words 2 and 3 keep their old contents; a subsequent read confirms this.
- Busy exclusion:
  - Stimulus: hold `req_valid`=1 throughout a 4-beat read.
  - Required: `req_ready`=0 until the `done` cycle. The second request is accepted exactly on the `done` cycle.
